// File: rtl/ov7670_sccb_config_if.sv
// Write-request handshake between the config sequencer (master) and the SCCB
// write engine (slave): one {id, addr, data_wr} transfer per start_tx pulse.
interface ov7670_sccb_config_if;
  logic       start_tx;
  logic       ready;
  logic       finish_tx;
  logic [6:0] id;
  logic [7:0] addr;
  logic [7:0] data_wr;

  modport master (output start_tx, id, addr, data_wr, input ready, finish_tx);
  modport slave  (input start_tx, id, addr, data_wr, output ready, finish_tx);
endinterface

// File: rtl/ov7670_sccb_config.sv
// OV7670 register-init sequencer: walks a {reg_addr, reg_data} table and issues
// one SCCB write per entry, honouring inline delay entries and an end marker.
module ov7670_sccb_config #(
  parameter logic        c_on         = 1'b1,
  parameter int unsigned c_autostart  = 1,
  parameter logic [6:0]  c_id         = 7'h21,
  parameter int unsigned c_nb_rom     = 8,
  parameter int unsigned c_ms_cycles  = 100000,
  parameter int unsigned c_nb_ms      = 17,
  parameter int unsigned c_timeout    = 200000,
  parameter logic [7:0]  c_delay_code = 8'hF0,
  parameter logic [15:0] c_end_word   = 16'hFFFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_cfg,
  ov7670_sccb_config_if.master        sccb,
  output logic [c_nb_rom-1:0]         rom_addr,
  input  logic [15:0]                 rom_data,
  output logic                        cfg_busy,
  output logic                        cfg_done,
  output logic                        cfg_err
);

  localparam int unsigned w_ms = (c_ms_cycles > 1) ? $clog2(c_ms_cycles) : 1;
  localparam int unsigned w_to = (c_timeout > 1) ? $clog2(c_timeout) : 1;
  localparam logic [w_ms-1:0] ms_last = w_ms'(c_ms_cycles - 1);
  localparam logic [w_to-1:0] to_last = w_to'(c_timeout - 1);

  typedef enum logic [2:0] {
    s_idle, s_fetch, s_decode, s_send, s_wait_tx, s_delay, s_next, s_done
  } state_t;

  state_t                state, state_nxt;
  logic                  start_q, auto_q, start_lvl, start_evt;
  logic                  start_tx, start_tx_nxt;
  logic [7:0]            addr, addr_nxt, data_wr, data_nxt;
  logic [c_nb_rom-1:0]   rom_addr_nxt;
  logic                  busy_nxt, done_nxt, err_nxt;
  logic [c_nb_ms-1:0]    unit_cnt, unit_nxt;
  logic [w_ms-1:0]       ms_cnt, ms_nxt;
  logic [w_to-1:0]       to_cnt, to_nxt;

  assign sccb.id       = c_id;
  assign sccb.start_tx = start_tx;
  assign sccb.addr     = addr;
  assign sccb.data_wr  = data_wr;

  // auto_q stands in for a start edge on the first cycle out of reset
  assign start_lvl = (start_cfg == c_on);
  assign start_evt = (start_lvl & ~start_q) | auto_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= s_idle;
      start_q  <= 1'b0;
      auto_q   <= 1'(c_autostart != 0);
      start_tx <= 1'b0;
      addr     <= '0;
      data_wr  <= '0;
      rom_addr <= '0;
      cfg_busy <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      unit_cnt <= '0;
      ms_cnt   <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      start_q  <= start_lvl;
      auto_q   <= 1'b0;
      start_tx <= start_tx_nxt;
      addr     <= addr_nxt;
      data_wr  <= data_nxt;
      rom_addr <= rom_addr_nxt;
      cfg_busy <= busy_nxt;
      cfg_done <= done_nxt;
      cfg_err  <= err_nxt;
      unit_cnt <= unit_nxt;
      ms_cnt   <= ms_nxt;
      to_cnt   <= to_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    start_tx_nxt = 1'b0;
    addr_nxt     = addr;
    data_nxt     = data_wr;
    rom_addr_nxt = rom_addr;
    done_nxt     = cfg_done;
    err_nxt      = cfg_err;
    unit_nxt     = unit_cnt;
    ms_nxt       = ms_cnt;
    to_nxt       = to_cnt;
    busy_nxt     = 1'b0;

    unique case (state)
      s_idle: begin
        if (start_evt) begin
          state_nxt    = s_fetch;
          rom_addr_nxt = '0;
          done_nxt     = 1'b0;
          err_nxt      = 1'b0;
        end
      end
      s_fetch: state_nxt = s_decode;
      s_decode: begin
        if (rom_data == c_end_word) begin
          state_nxt = s_done;
        end else if (rom_data[15:8] == c_delay_code) begin
          unit_nxt  = c_nb_ms'(rom_data[7:0]);
          ms_nxt    = '0;
          state_nxt = (rom_data[7:0] == 8'd0) ? s_next : s_delay;
        end else begin
          addr_nxt  = rom_data[15:8];
          data_nxt  = rom_data[7:0];
          state_nxt = s_send;
        end
      end
      s_send: begin
        if (sccb.ready) begin
          start_tx_nxt = 1'b1;
          to_nxt       = '0;
          state_nxt    = s_wait_tx;
        end
      end
      s_wait_tx: begin
        if (sccb.finish_tx) begin
          state_nxt = s_next;
        end else if (to_cnt == to_last) begin
          err_nxt   = 1'b1;
          state_nxt = s_done;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
      end
      // ms_cnt wraps once per delay unit; leave after the last unit expires
      s_delay: begin
        if (ms_cnt == ms_last) begin
          ms_nxt   = '0;
          unit_nxt = unit_cnt - 1'b1;
          if (unit_cnt == c_nb_ms'(1)) state_nxt = s_next;
        end else begin
          ms_nxt = ms_cnt + 1'b1;
        end
      end
      s_next: begin
        if (&rom_addr) begin
          state_nxt = s_done;
        end else begin
          rom_addr_nxt = rom_addr + 1'b1;
          state_nxt    = s_fetch;
        end
      end
      s_done:  state_nxt = s_idle;
      default: state_nxt = s_idle;
    endcase

    if (state_nxt == s_done) done_nxt = 1'b1;
    busy_nxt = !(state_nxt inside {s_idle, s_done});
  end

endmodule

// File: doc/ov7670_sccb_config.md
Name: ov7670_sccb_config

Overview:
- Sequencer directly upstream of the SCCB write master. It walks an external register-init table of {reg_addr, reg_data} words and issues one 3-phase SCCB write per entry via the master's start_tx/ready/finish_tx handshake.
- Supports inline delay entries, for example after the OV7670 soft reset, and an end-of-table marker.
- Reports busy, done and error to the top level, which feeds a push button or auto-start.

Parameters:
- c_on, 1'b1: active level of start_cfg.
- c_autostart, 1: 1 means a configuration run starts automatically after reset release.
- c_id, 7'h21: 7-bit SCCB slave ID driven on id (write address 0x42).
- c_nb_rom, 8: width of rom_addr; table depth is 2^c_nb_rom.
- c_ms_cycles, 100000: clk cycles per delay unit (1 ms at 10 ns).
- c_nb_ms, 17: width of the delay-unit counter.
- c_timeout, 200000: max clk cycles from start_tx to finish_tx before error.
- c_delay_code, 8'hF0: table addr byte marking a delay entry.
- c_end_word, 16'hFFFF: table word marking end of table.

Ports:
- clk  in  1  fpga clock
- rst  in  1  reset, asynchronous, active-high
- start_cfg  in  1  request a configuration run (level; edge-detected internally)
- ready  in  1  SCCB master idle
- finish_tx  in  1  SCCB master one-cycle completion pulse
- start_tx  out  1  one-cycle write request to master
- id  out  7  slave ID, constant c_id
- addr  out  8  camera register address
- data_wr  out  8  camera register data
- rom_addr  out  c_nb_rom  table read address
- rom_data  in  16  table word {reg_addr[15:8], reg_data[7:0]}, valid 1 clk after rom_addr
- cfg_busy  out  1  run in progress
- cfg_done  out  1  run completed, held
- cfg_err  out  1  timeout occurred, sticky until next run starts

Behaviour:
- Reset values: start_tx=0, addr=0, data_wr=0, rom_addr=0, cfg_busy=0, cfg_done=0, cfg_err=0, state IDLE. id is always c_id.
- Start detection: a rising edge of start_cfg (registered previous value, reset to 0) starts a run.
- Auto-start: with c_autostart=1, the first cycle after reset deassertion is treated as a start.
- States:
  - IDLE: cfg_busy=0. On start, go to FETCH with rom_addr=0, cfg_done=0, cfg_err=0.
  - FETCH: rom_addr stable for 1 cycle, then go to DECODE. Table read latency is exactly 1.
  - DECODE: register rom_data.
    - If word == c_end_word, go to DONE.
    - Else if rom_data[15:8] == c_delay_code, load unit counter with rom_data[7:0] and go to DELAY. A count of 0 goes straight to NEXT.
    - Else latch addr/data_wr and go to SEND.
  - SEND: wait for ready=1. In that cycle pulse start_tx for exactly 1 clk, clear the timeout counter, go to WAIT_TX. start_tx is never asserted while ready=0.
  - WAIT_TX: addr/data_wr held constant. On finish_tx go to NEXT. If the timeout counter reaches c_timeout-1 first, set cfg_err=1 and go to DONE.
  - DELAY: a cycle counter 0..c_ms_cycles-1 decrements the unit counter at each wrap. When the unit counter reaches 0, go to NEXT. Total wait is data × c_ms_cycles cycles, ±2.
  - NEXT: if rom_addr is all ones, go to DONE (table exhausted without marker, not an error). Else rom_addr+1 and go to FETCH.
  - DONE: cfg_done=1, cfg_busy=0, go to IDLE. cfg_done stays 1 in IDLE until the next start.
- cfg_busy=1 in every state except IDLE/DONE.
- A start edge during a run is ignored; no restart mid-run.
- Reset mid-run: everything returns to reset values immediately. A transfer already in progress in the master is aborted by the same rst. With autostart, the table restarts at index 0.
- A finish_tx seen outside WAIT_TX is ignored.
- Per-entry overhead beyond the SCCB transfer: ≤4 clk.

Test Plan:
- Table {0x1280, 0xF00A, 0x1101, 0xFFFF}, c_ms_cycles=10, master model ready/finish after 50 clk, autostart -> writes addr 0x12/data 0x80, then ~100 clk gap, then 0x11/0x01. cfg_done=1 with exactly 2 start_tx pulses, id=0x21.
- Master holds ready=0 for 30 clk after the first finish -> second start_tx delayed until ready=1. Pulse is 1 clk wide; addr/data stable until finish_tx.
- Model never returns finish_tx, c_timeout=100 -> cfg_err=1 and cfg_done=1 at ~100 clk after start_tx, no further start_tx. A new start_cfg edge clears cfg_err and reruns from index 0.
- Delay entry 0xF000 -> no DELAY wait; next entry is fetched within 4 clk.
- rst asserted during the 2nd write's WAIT_TX -> all outputs at reset values the same cycle. After release, rom_addr restarts at 0 and the first write is 0x12/0x80 again.
- c_nb_rom=2, table with no end marker {0x0101,0x0202,0x0303,0x0404} -> 4 writes, then cfg_done=1, cfg_err=0, rom_addr does not wrap to 0 while busy.
